// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: slave-side AHB bus bundle between master/decoder and ahb_slave_mem
interface ahb_slave_mem_if;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hburst;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  modport master (output hsel, haddr, hwrite, hburst, hready, hwdata, input hrdata, hreadyout, hresp);
  modport slave (input hsel, haddr, hwrite, hburst, hready, hwdata, output hrdata, hreadyout, hresp);
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: word-addressed AHB memory with wait states, two-cycle error response
// and write-to-read forwarding for back-to-back transfers.
module ahb_slave_mem #(
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 0
) (
  input logic hclk,
  input logic hresetn,
  ahb_slave_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  state_t state, state_n;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx, load_idx;
  logic [2:0] cnt;
  logic [31:0] rdata;
  logic wr, err_a, accept, load, fwd, ready, resp;
  logic unused;
  assign unused = ^bus.hburst;
  assign accept = bus.hsel & bus.hready & ready;
  assign err_a = |bus.haddr[1:0] | |bus.haddr[31:AW+2];
  // a read enters DATA either from WAIT (latched transfer) or straight from the bus
  assign load_idx = state == S_WAIT ? idx : bus.haddr[AW+1:2];
  assign load = state_n == S_DATA && !(state == S_WAIT ? wr : bus.hwrite);
  assign fwd = state == S_DATA && wr && idx == load_idx;
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_WAIT: state_n = cnt == 3'd1 ? S_DATA : S_WAIT;
      S_ERR1: state_n = S_ERR2;
      default: state_n = !accept ? S_IDLE : err_a ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
    endcase
  end
  always_comb begin
    ready = state inside {S_IDLE, S_DATA, S_ERR2};
    resp = state inside {S_ERR1, S_ERR2};
  end
  always_ff @(posedge hclk or negedge hresetn)
    if (!hresetn) begin
      idx <= '0;
      wr <= 1'b0;
      cnt <= 3'd0;
      rdata <= 32'd0;
    end else begin
      if (accept) begin
        idx <= bus.haddr[AW+1:2];
        wr <= bus.hwrite;
      end
      cnt <= accept && !err_a ? 3'(WAIT_STATES) : state == S_WAIT ? cnt - 3'd1 : cnt;
      if (load) rdata <= fwd ? bus.hwdata : mem[load_idx];
    end
  always_ff @(posedge hclk)
    if (state == S_DATA && wr) mem[idx] <= bus.hwdata;
  assign bus.hrdata = rdata;
  assign bus.hreadyout = ready;
  assign bus.hresp = resp;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: three instances (0/2/3 wait states) checked against a sequential memory model.
module tb_ahb_slave_mem;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic [2:0] rstn, sel, rdy, wrt, ro, rsp;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [2:0] burst [3];
  logic [31:0] rdat [3];
  for (genvar g = 0; g < 3; g++) begin : gd
    ahb_slave_mem_if bus ();
    assign bus.hsel = sel[g];
    assign bus.hready = rdy[g];
    assign bus.haddr = addr[g];
    assign bus.hwrite = wrt[g];
    assign bus.hwdata = wdat[g];
    assign bus.hburst = burst[g];
    assign rdat[g] = bus.hrdata;
    assign ro[g] = bus.hreadyout;
    assign rsp[g] = bus.hresp;
    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(g == 0 ? 0 : g + 1)) dut (
      .hclk(clk), .hresetn(rstn[g]), .bus(bus));
  end
  logic [31:0] mm [3][DEPTH];
  bit kn [3][DEPTH];
  logic [31:0] exp_rd [3];
  bit rd_kn [3];
  logic [31:0] qa [$];
  logic [31:0] qd [$];
  bit qw [$];
  int qg [$];
  int n_tests = 0, n_fail = 0;
  function automatic int ws(int d);
    return d == 0 ? 0 : d + 1;
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(logic [31:0] a, bit w, logic [31:0] dt, int gap);
    qa.push_back(a);
    qw.push_back(w);
    qd.push_back(dt);
    qg.push_back(gap);
  endtask
  task automatic drive_idle(int d);
    int r = $urandom_range(0, 2);
    sel[d] = r == 1;
    rdy[d] = r == 2;
    addr[d] = $urandom;
    wrt[d] = 1'($urandom);
    burst[d] = 3'($urandom);
  endtask
  task automatic drive_addr(int d, int i);
    sel[d] = 1'b1;
    rdy[d] = 1'b1;
    addr[d] = qa[i];
    wrt[d] = qw[i];
    burst[d] = 3'($urandom);
  endtask
  task automatic check_idle(int d, string tag);
    chk($sformatf("%s_d%0d_ready", tag, d), 32'(ro[d]), 32'd1);
    chk($sformatf("%s_d%0d_resp", tag, d), 32'(rsp[d]), 32'd0);
    if (rd_kn[d]) chk($sformatf("%s_d%0d_rdata", tag, d), rdat[d], exp_rd[d]);
  endtask
  // Each transfer: k wait cycles then one ready cycle if legal, else two error cycles.
  task automatic run(int d);
    int n = qa.size();
    for (int i = 0; i < n; i++) begin
      bit legal;
      int len, idx;
      if (i == 0 || qg[i] > 0) begin
        for (int j = 0; j < qg[i]; j++) begin
          @(negedge clk);
          check_idle(d, "gap");
          drive_idle(d);
        end
        @(negedge clk);
        check_idle(d, "addr");
        drive_addr(d, i);
      end
      legal = qa[i][1:0] == 2'b00 && qa[i] < 32'(DEPTH * 4);
      idx = legal ? int'(qa[i] >> 2) : 0;
      len = legal ? ws(d) + 1 : 2;
      for (int c = 0; c < len; c++) begin
        bit last = c == len - 1;
        @(negedge clk);
        if (last && legal && !qw[i]) begin
          exp_rd[d] = mm[d][idx];
          rd_kn[d] = kn[d][idx];
        end
        chk($sformatf("d%0d_t%0d_c%0d_ready", d, i, c), 32'(ro[d]), 32'(last));
        chk($sformatf("d%0d_t%0d_c%0d_resp", d, i, c), 32'(rsp[d]), 32'(!legal));
        if (rd_kn[d]) chk($sformatf("d%0d_t%0d_c%0d_rdata", d, i, c), rdat[d], exp_rd[d]);
        wdat[d] = last ? qd[i] : $urandom;
        if (last) begin
          if (legal && qw[i]) begin
            mm[d][idx] = qd[i];
            kn[d][idx] = 1'b1;
          end
          if (i + 1 < n && qg[i + 1] == 0) drive_addr(d, i + 1);
          else drive_idle(d);
        end else begin
          sel[d] = 1'(c);
          rdy[d] = 1'($urandom);
          addr[d] = $urandom;
          wrt[d] = 1'($urandom);
        end
      end
    end
    @(negedge clk);
    check_idle(d, "end");
    drive_idle(d);
    qa.delete();
    qw.delete();
    qd.delete();
    qg.delete();
  endtask
  initial begin
    rstn = '1;
    sel = '0;
    rdy = '0;
    wrt = '0;
    for (int d = 0; d < 3; d++) begin
      addr[d] = 32'd0;
      wdat[d] = 32'd0;
      burst[d] = 3'd0;
      exp_rd[d] = 32'd0;
      rd_kn[d] = 1'b1;
    end
    #1 rstn = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle(d, "reset");
    rstn = '1;
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check_idle(d, "post_reset");
        drive_idle(d);
      end
    end
    push(32'h10, 1, 32'hDEADBEEF, 1);
    push(32'h10, 0, 32'h0, 2);
    push(32'h24, 1, 32'hA5A5A5A5, 1);
    push(32'h20, 1, 32'h12345678, 1);
    push(32'h20, 0, 32'h0, 0);
    push(32'h20, 1, 32'h87654321, 1);
    push(32'h24, 0, 32'h0, 0);
    push(32'h0, 1, 32'h0BADCAFE, 1);
    push(32'h402, 1, 32'hFFFFFFFF, 1);
    push(32'h400, 0, 32'h0, 0);
    push(32'h0, 0, 32'h0, 1);
    run(0);
    push(32'h10, 1, 32'hDEADBEEF, 1);
    push(32'h10, 0, 32'h0, 1);
    push(32'h402, 1, 32'hFFFFFFFF, 0);
    push(32'h10, 0, 32'h0, 0);
    run(1);
    push(32'h30, 1, 32'h11111111, 1);
    run(2);
    @(negedge clk);
    check_idle(2, "rst_addr");
    sel[2] = 1'b1;
    rdy[2] = 1'b1;
    addr[2] = 32'h30;
    wrt[2] = 1'b1;
    @(negedge clk);
    chk("rst_wait1_ready", 32'(ro[2]), 32'd0);
    sel[2] = 1'b0;
    rdy[2] = 1'b0;
    wdat[2] = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_wait2_ready", 32'(ro[2]), 32'd0);
    rstn[2] = 1'b0;
    #1;
    chk("rst_async_ready", 32'(ro[2]), 32'd1);
    chk("rst_async_resp", 32'(rsp[2]), 32'd0);
    chk("rst_async_rdata", rdat[2], 32'd0);
    exp_rd[2] = 32'd0;
    rd_kn[2] = 1'b1;
    @(negedge clk);
    rstn[2] = 1'b1;
    push(32'h30, 0, 32'h0, 2);
    run(2);
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 8; k++) push(32'(k * 4), 1, $urandom, k == 0 ? 1 : 0);
      run(d);
      for (int t = 0; t < 40; t++) begin
        int r = $urandom_range(0, 9);
        logic [31:0] a;
        a = r == 0 ? 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3)) :
            r == 1 ? ($urandom | 32'h400) : 32'($urandom_range(0, 7) * 4);
        push(a, 1'($urandom), $urandom, $urandom_range(0, 3) > 1 ? $urandom_range(1, 2) : 0);
      end
      run(d);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
